// File: rtl/ctrl_pkg.sv
// Shared decode constants: opcodes, ALU select codes, control-word layout and FSM encoding.
// Also holds the output bundle type and a helper for conditional-branch words.
package ctrl_pkg;

  localparam logic [3:0] OpJc    = 4'd0;
  localparam logic [3:0] OpJnc   = 4'd1;
  localparam logic [3:0] OpCmpi  = 4'd2;
  localparam logic [3:0] OpCmpm  = 4'd3;
  localparam logic [3:0] OpLit   = 4'd4;
  localparam logic [3:0] OpIn    = 4'd5;
  localparam logic [3:0] OpLd    = 4'd6;
  localparam logic [3:0] OpSt    = 4'd7;
  localparam logic [3:0] OpJz    = 4'd8;
  localparam logic [3:0] OpJnz   = 4'd9;
  localparam logic [3:0] OpAddi  = 4'd10;
  localparam logic [3:0] OpAddm  = 4'd11;
  localparam logic [3:0] OpJmp   = 4'd12;
  localparam logic [3:0] OpOut   = 4'd13;
  localparam logic [3:0] OpNandi = 4'd14;
  localparam logic [3:0] OpNandm = 4'd15;

  localparam logic [2:0] SCmp  = 3'b001;
  localparam logic [2:0] SPass = 3'b010;
  localparam logic [2:0] SAdd  = 3'b011;
  localparam logic [2:0] SNand = 3'b100;

  // 13-bit control word; field order fixes the bit positions (inc_pc is bit 12, s is [2:0]).
  typedef struct packed {
    logic       inc_pc;
    logic       load_pc;
    logic       load_a;
    logic       load_flags;
    logic       cs_ram;
    logic       we_ram;
    logic       oe_alu;
    logic       oe_in;
    logic       oe_oprnd;
    logic       load_out;
    logic [2:0] s;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StHalt  = 2'd2
  } state_e;

  typedef struct packed {
    ctrl_word_t word;
    logic       phase;
    logic       halted;
    logic       bus_error;
  } dec_out_t;

  function automatic ctrl_word_t branch_word(input logic taken);
    ctrl_word_t w;
    w         = '0;
    w.oe_alu  = 1'b1;
    w.load_pc = taken;
    w.inc_pc  = ~taken;
    return w;
  endfunction

endpackage

// File: rtl/decode_seq_if.sv
// Datapath-facing bundle of the sequencer: opcode/flags/handshake in, strobes and status out.
interface decode_seq_if #(
  parameter int unsigned OPCODE_W = 4
) ();
  logic [OPCODE_W-1:0] Instr;
  logic                C_flag;
  logic                Z_flag;
  logic                halt;
  logic                mem_ready;
  logic                IncPC;
  logic                LoadPC;
  logic                LoadA;
  logic                LoadFlags;
  logic                CsRAM;
  logic                WeRAM;
  logic                OeALU;
  logic                OeIN;
  logic                OeOprnd;
  logic                LoadOut;
  logic [2:0]          S;
  logic                Phase;
  logic                halted;
  logic                bus_error;

  modport master (
    output Instr, C_flag, Z_flag, halt, mem_ready,
    input  IncPC, LoadPC, LoadA, LoadFlags, CsRAM, WeRAM, OeALU, OeIN, OeOprnd, LoadOut,
    input  S, Phase, halted, bus_error
  );

  modport slave (
    input  Instr, C_flag, Z_flag, halt, mem_ready,
    output IncPC, LoadPC, LoadA, LoadFlags, CsRAM, WeRAM, OeALU, OeIN, OeOprnd, LoadOut,
    output S, Phase, halted, bus_error
  );
endinterface

// File: rtl/ctrl_rom.sv
// Combinational opcode + flags to control-word table used during the execute phase.
module ctrl_rom
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] instr_i,
  input  logic                c_flag_i,
  input  logic                z_flag_i,
  output ctrl_word_t          word_o
);

  logic       high_nz;
  logic [3:0] op;

  // Any set bit above the base nibble turns the opcode into a NOP.
  assign high_nz = (instr_i >> 4) != '0;
  assign op      = instr_i[3:0];

  always_comb begin
    word_o = '0;
    if (high_nz) begin
      word_o.inc_pc = 1'b1;
      word_o.oe_alu = 1'b1;
    end else begin
      unique case (op)
        OpJc:  word_o = branch_word(c_flag_i);
        OpJnc: word_o = branch_word(~c_flag_i);
        OpJz:  word_o = branch_word(z_flag_i);
        OpJnz: word_o = branch_word(~z_flag_i);
        OpJmp: word_o = branch_word(1'b1);
        OpCmpi: begin
          word_o.load_flags = 1'b1;
          word_o.s          = SCmp;
          word_o.oe_oprnd   = 1'b1;
        end
        OpCmpm: begin
          word_o.inc_pc     = 1'b1;
          word_o.load_flags = 1'b1;
          word_o.s          = SCmp;
          word_o.cs_ram     = 1'b1;
        end
        OpLit, OpIn: begin
          word_o.load_a     = 1'b1;
          word_o.load_flags = 1'b1;
          word_o.s          = SPass;
          word_o.oe_oprnd   = (op == OpLit);
          word_o.oe_in      = (op == OpIn);
        end
        OpLd: begin
          word_o.inc_pc     = 1'b1;
          word_o.load_a     = 1'b1;
          word_o.load_flags = 1'b1;
          word_o.s          = SPass;
          word_o.cs_ram     = 1'b1;
        end
        OpSt: begin
          word_o.inc_pc = 1'b1;
          word_o.cs_ram = 1'b1;
          word_o.we_ram = 1'b1;
          word_o.oe_alu = 1'b1;
        end
        OpAddi, OpNandi: begin
          word_o.load_a     = 1'b1;
          word_o.load_flags = 1'b1;
          word_o.s          = (op == OpAddi) ? SAdd : SNand;
          word_o.oe_oprnd   = 1'b1;
        end
        OpAddm, OpNandm: begin
          word_o.inc_pc     = 1'b1;
          word_o.load_a     = 1'b1;
          word_o.load_flags = 1'b1;
          word_o.s          = (op == OpAddm) ? SAdd : SNand;
          word_o.cs_ram     = 1'b1;
        end
        OpOut: begin
          word_o.oe_alu   = 1'b1;
          word_o.load_out = 1'b1;
        end
        default: begin
          word_o.inc_pc = 1'b1;
          word_o.oe_alu = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_seq.sv
// FETCH/EXEC/HALT sequencer with RAM wait-state stalling, stall timeout and optional output
// register. The bus error fires on the TIMEOUT-th consecutive stall cycle of one instruction.
module decode_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W  = 4,
  parameter bit          USE_READY = 1'b0,
  parameter int unsigned TIMEOUT   = 15,
  parameter bit          OUT_REG   = 1'b0
) (
  input logic         clock,
  input logic         reset,
  decode_seq_if.slave bus
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] stall_q, stall_d, stall_inc;
  logic       err_q, err_d;
  logic       ram_stall;
  ctrl_word_t rom_word;
  dec_out_t   out_c, out_sel;

  ctrl_rom #(
    .OPCODE_W(OPCODE_W)
  ) u_ctrl_rom (
    .instr_i (bus.Instr),
    .c_flag_i(bus.C_flag),
    .z_flag_i(bus.Z_flag),
    .word_o  (rom_word)
  );

  assign stall_inc = stall_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    stall_d       = stall_q;
    err_d         = err_q;
    ram_stall     = 1'b0;
    out_c         = '0;
    out_c.bus_error = err_q;
    unique case (state_q)
      StFetch: begin
        if (bus.halt) begin
          state_d = StHalt;
        end else begin
          out_c.word.inc_pc = 1'b1;
          out_c.word.oe_alu = 1'b1;
          state_d           = StExec;
        end
      end
      StExec: begin
        out_c.phase = 1'b1;
        out_c.word  = rom_word;
        ram_stall   = USE_READY && rom_word.cs_ram && !bus.mem_ready;
        if (ram_stall) begin
          // Hold the access, suppress every state-changing load until RAM answers.
          out_c.word.inc_pc     = 1'b0;
          out_c.word.load_pc    = 1'b0;
          out_c.word.load_a     = 1'b0;
          out_c.word.load_flags = 1'b0;
          out_c.word.load_out   = 1'b0;
          if (stall_inc == TimeoutCnt) begin
            err_d   = 1'b1;
            state_d = StHalt;
            stall_d = '0;
          end else begin
            stall_d = stall_inc;
          end
        end else begin
          state_d = StFetch;
          stall_d = '0;
        end
      end
      StHalt: begin
        out_c.halted = 1'b1;
        if (!bus.halt && !err_q) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    dec_out_t out_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        out_q <= '0;
      end else begin
        out_q <= out_c;
      end
    end
    assign out_sel = out_q;
  end else begin : g_out_comb
    // State already sits at FETCH during reset; gate so outputs read zero immediately.
    assign out_sel = reset ? out_c : '0;
  end

  assign bus.IncPC     = out_sel.word.inc_pc;
  assign bus.LoadPC    = out_sel.word.load_pc;
  assign bus.LoadA     = out_sel.word.load_a;
  assign bus.LoadFlags = out_sel.word.load_flags;
  assign bus.CsRAM     = out_sel.word.cs_ram;
  assign bus.WeRAM     = out_sel.word.we_ram;
  assign bus.OeALU     = out_sel.word.oe_alu;
  assign bus.OeIN      = out_sel.word.oe_in;
  assign bus.OeOprnd   = out_sel.word.oe_oprnd;
  assign bus.LoadOut   = out_sel.word.load_out;
  assign bus.S         = out_sel.word.s;
  assign bus.Phase     = out_sel.phase;
  assign bus.halted    = out_sel.halted;
  assign bus.bus_error = out_sel.bus_error;

endmodule

// File: tb/tb_decode_seq.sv
// Drives three decode_seq variants from shared stimulus and checks each cycle against a
// behavioural model of the fetch/execute/halt rules, plus hand-computed literal points.
module tb_decode_seq;

  localparam bit [9:0] INC  = 10'b1000000000;
  localparam bit [9:0] LPC  = 10'b0100000000;
  localparam bit [9:0] LA   = 10'b0010000000;
  localparam bit [9:0] LF   = 10'b0001000000;
  localparam bit [9:0] CS   = 10'b0000100000;
  localparam bit [9:0] WE   = 10'b0000010000;
  localparam bit [9:0] OALU = 10'b0000001000;
  localparam bit [9:0] OIN  = 10'b0000000100;
  localparam bit [9:0] OOP  = 10'b0000000010;
  localparam bit [9:0] LOUT = 10'b0000000001;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [5:0] instr  = '0;
  logic       c_flag = 1'b0;
  logic       z_flag = 1'b0;
  logic       halt   = 1'b0;
  logic       rdy    = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  decode_seq_if #(.OPCODE_W(6)) if_a ();
  decode_seq_if #(.OPCODE_W(6)) if_b ();
  decode_seq_if #(.OPCODE_W(4)) if_c ();

  assign if_a.Instr = instr;
  assign if_a.C_flag = c_flag;
  assign if_a.Z_flag = z_flag;
  assign if_a.halt = halt;
  assign if_a.mem_ready = rdy;
  assign if_b.Instr = instr;
  assign if_b.C_flag = c_flag;
  assign if_b.Z_flag = z_flag;
  assign if_b.halt = halt;
  assign if_b.mem_ready = rdy;
  assign if_c.Instr = instr[3:0];
  assign if_c.C_flag = c_flag;
  assign if_c.Z_flag = z_flag;
  assign if_c.halt = halt;
  assign if_c.mem_ready = rdy;

  decode_seq #(.OPCODE_W(6), .USE_READY(1'b1), .TIMEOUT(4), .OUT_REG(1'b0)) u_a (
    .clock(clk), .reset(rst_n), .bus(if_a)
  );
  decode_seq #(.OPCODE_W(6), .USE_READY(1'b1), .TIMEOUT(4), .OUT_REG(1'b1)) u_b (
    .clock(clk), .reset(rst_n), .bus(if_b)
  );
  decode_seq #(.OPCODE_W(4), .USE_READY(1'b0), .TIMEOUT(15), .OUT_REG(1'b0)) u_c (
    .clock(clk), .reset(rst_n), .bus(if_c)
  );

  logic [15:0] act_a, act_b, act_c;
  assign act_a = {if_a.IncPC, if_a.LoadPC, if_a.LoadA, if_a.LoadFlags, if_a.CsRAM, if_a.WeRAM,
                  if_a.OeALU, if_a.OeIN, if_a.OeOprnd, if_a.LoadOut, if_a.S, if_a.Phase,
                  if_a.halted, if_a.bus_error};
  assign act_b = {if_b.IncPC, if_b.LoadPC, if_b.LoadA, if_b.LoadFlags, if_b.CsRAM, if_b.WeRAM,
                  if_b.OeALU, if_b.OeIN, if_b.OeOprnd, if_b.LoadOut, if_b.S, if_b.Phase,
                  if_b.halted, if_b.bus_error};
  assign act_c = {if_c.IncPC, if_c.LoadPC, if_c.LoadA, if_c.LoadFlags, if_c.CsRAM, if_c.WeRAM,
                  if_c.OeALU, if_c.OeIN, if_c.OeOprnd, if_c.LoadOut, if_c.S, if_c.Phase,
                  if_c.halted, if_c.bus_error};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Strobes (10 bits) and ALU select for one opcode under the given flags.
  function automatic logic [12:0] word_of(input int op, input bit c, input bit z);
    bit [9:0] nop = INC | OALU;
    bit [9:0] jmp = LPC | OALU;
    if (op > 15) return {nop, 3'b000};
    case (op)
      0:  return {(c ? jmp : nop), 3'b000};
      1:  return {(!c ? jmp : nop), 3'b000};
      2:  return {LF | OOP, 3'b001};
      3:  return {INC | LF | CS, 3'b001};
      4:  return {LA | LF | OOP, 3'b010};
      5:  return {LA | LF | OIN, 3'b010};
      6:  return {INC | LA | LF | CS, 3'b010};
      7:  return {INC | CS | WE | OALU, 3'b000};
      8:  return {(z ? jmp : nop), 3'b000};
      9:  return {(!z ? jmp : nop), 3'b000};
      10: return {LA | LF | OOP, 3'b011};
      11: return {INC | LA | LF | CS, 3'b011};
      12: return {jmp, 3'b000};
      13: return {OALU | LOUT, 3'b000};
      14: return {LA | LF | OOP, 3'b100};
      default: return {INC | LA | LF | CS, 3'b100};
    endcase
  endfunction

  // phase: 0 fetch, 1 execute, 2 halted. Output layout {strobes, S, Phase, halted, bus_error}.
  task automatic model(input bit ur, input int tmo, input int op, inout int phase,
                       inout int stalls, inout bit err, output logic [15:0] e);
    logic [12:0] w;
    e = '0;
    if (!rst_n) begin
      phase = 0; stalls = 0; err = 0;
      return;
    end
    e[0] = err;
    if (phase == 0) begin
      if (halt) phase = 2;
      else begin
        e[15:6] = INC | OALU;
        phase = 1;
      end
    end else if (phase == 1) begin
      w = word_of(op, c_flag, z_flag);
      e[2] = 1'b1;
      if (ur && (w[12:3] & CS) != 0 && !rdy) begin
        w[12:3] = w[12:3] & ~(INC | LPC | LA | LF | LOUT);
        stalls++;
        if (stalls == tmo) begin
          err = 1; phase = 2; stalls = 0;
        end
      end else begin
        phase = 0; stalls = 0;
      end
      e[15:3] = w;
    end else begin
      e[1] = 1'b1;
      if (!halt && !err) phase = 0;
    end
  endtask

  int          ph_a = 0, st_a = 0, ph_c = 0, st_c = 0;
  bit          err_a = 0, err_c = 0;
  logic [15:0] prev_a = '0;

  initial begin
    forever begin
      logic [15:0] ea, eb, ec;
      @(negedge clk);
      model(1'b1, 4, int'(instr), ph_a, st_a, err_a, ea);
      model(1'b0, 15, int'(instr[3:0]), ph_c, st_c, err_c, ec);
      eb = rst_n ? prev_a : '0;
      prev_a = rst_n ? ea : '0;
      check("cyc_a", act_a, ea);
      check("cyc_b", act_b, eb);
      check("cyc_c", act_c, ec);
    end
  end

  task automatic drive(input bit rn, input logic [5:0] i, input bit c, input bit z,
                       input bit h, input bit r);
    @(posedge clk);
    #1;
    rst_n = rn; instr = i; c_flag = c; z_flag = z; halt = h; rdy = r;
    @(negedge clk);
  endtask

  task automatic cyc(input logic [5:0] i, input bit c, input bit z, input bit h, input bit r);
    drive(1'b1, i, c, z, h, r);
  endtask

  initial begin
    bit slow;
    drive(0, 6'd0, 0, 0, 0, 0);
    drive(0, 6'd0, 0, 0, 0, 0);
    check("rst_a", act_a, 16'h0);
    check("rst_b", act_b, 16'h0);
    check("rst_c", act_c, 16'h0);

    cyc(6'd4, 0, 0, 0, 1);
    check("lit_f_inc", if_a.IncPC, 1);
    check("lit_f_oealu", if_a.OeALU, 1);
    check("lit_f_phase", if_a.Phase, 0);
    check("lit_f_b_zero", act_b, 16'h0);
    cyc(6'd4, 0, 0, 0, 1);
    check("lit_e_la", if_a.LoadA, 1);
    check("lit_e_lf", if_a.LoadFlags, 1);
    check("lit_e_s", if_a.S, 3'b010);
    check("lit_e_oop", if_a.OeOprnd, 1);
    check("lit_e_phase", if_a.Phase, 1);
    check("lit_e_inc", if_a.IncPC, 0);
    check("lit_b_lag_inc", if_b.IncPC, 1);

    cyc(6'd0, 1, 0, 0, 1);
    cyc(6'd0, 1, 0, 0, 1);
    check("jc_taken_lpc", if_a.LoadPC, 1);
    check("jc_taken_inc", if_a.IncPC, 0);
    cyc(6'd0, 0, 0, 0, 1);
    cyc(6'd0, 0, 0, 0, 1);
    check("jc_not_inc", if_a.IncPC, 1);
    check("jc_not_lpc", if_a.LoadPC, 0);
    cyc(6'd9, 0, 0, 0, 1);
    cyc(6'd9, 0, 0, 0, 1);
    check("jnz_taken_lpc", if_a.LoadPC, 1);
    cyc(6'd8, 0, 0, 0, 1);
    cyc(6'd8, 0, 0, 0, 1);
    check("jz_not_inc", if_a.IncPC, 1);
    check("jz_not_lpc", if_a.LoadPC, 0);

    cyc(6'd6, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(6'd6, 0, 0, 0, 0);
      check("ld_stall_cs", if_a.CsRAM, 1);
      check("ld_stall_la", if_a.LoadA, 0);
      check("ld_stall_inc", if_a.IncPC, 0);
      if (k == 0) check("ld_noready_c_la", if_c.LoadA, 1);
    end
    cyc(6'd6, 0, 0, 0, 1);
    check("ld_done_la", if_a.LoadA, 1);
    check("ld_done_inc", if_a.IncPC, 1);

    cyc(6'd10, 0, 0, 0, 1);
    cyc(6'd10, 0, 0, 1, 1);
    check("addi_halt_la", if_a.LoadA, 1);
    check("addi_halt_s", if_a.S, 3'b011);
    cyc(6'd10, 0, 0, 1, 1);
    check("halt_fetch_inc", if_a.IncPC, 0);
    check("halt_fetch_hl", if_a.halted, 0);
    cyc(6'd10, 0, 0, 0, 1);
    check("halt_state_hl", if_a.halted, 1);
    check("halt_state_inc", if_a.IncPC, 0);
    cyc(6'b010100, 0, 0, 0, 1);
    check("halt_exit_inc", if_a.IncPC, 1);
    check("halt_exit_hl", if_a.halted, 0);
    cyc(6'b010100, 0, 0, 0, 1);
    check("nop_inc", if_a.IncPC, 1);
    check("nop_oealu", if_a.OeALU, 1);
    check("nop_la", if_a.LoadA, 0);
    check("nop_phase", if_a.Phase, 1);

    cyc(6'd7, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(6'd7, 0, 0, 0, 0);
      check("st_stall_we", if_a.WeRAM, 1);
      check("st_stall_inc", if_a.IncPC, 0);
      check("st_stall_err", if_a.bus_error, 0);
    end
    cyc(6'd7, 0, 0, 0, 0);
    check("to_err", if_a.bus_error, 1);
    check("to_halted", if_a.halted, 1);
    check("to_we_drop", if_a.WeRAM, 0);
    check("to_b_lag_we", if_b.WeRAM, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(6'd7, 0, 0, 0, 1);
      check("to_sticky_err", if_a.bus_error, 1);
      check("to_sticky_hl", if_a.halted, 1);
    end
    drive(0, 6'd7, 0, 0, 0, 1);
    check("to_rst_err", if_a.bus_error, 0);
    check("to_rst_a", act_a, 16'h0);

    slow = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] i;
      bit rn, r;
      if (n % 64 == 0) slow = ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 299) != 0);
      i[3:0] = 4'($urandom_range(0, 15));
      i[5:4] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(rn, i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), r);
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
